// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared constants for the UART MMIO controller.
//   - Register offsets relative to the I/O region base.
//   - Bit positions inside the status register.
package uart_mmio_pkg;

    localparam logic [27:0] OFF_STATUS = 28'h0;
    localparam logic [27:0] OFF_RXDATA = 28'h4;
    localparam logic [27:0] OFF_TXDATA = 28'h8;
    localparam logic [27:0] OFF_LEVELS = 28'hC;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_RX_OVF       = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO.
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_wdata      write request and data
//   i_pop                read request (ignored while empty)
//   o_rdata              head entry, 0 while empty
//   o_full, o_empty      occupancy flags
//   o_count              entries held, 0..DEPTH
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once pushed.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART sequencer for the CPU I/O region.
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_addr, i_wdata, i_we, i_re     CPU data-memory access (single cycle)
//   o_rdata                         registered load result
//   o_uart_data_in(_valid), i_uart_data_in_ready    TX handshake to UART
//   i_uart_data_out(_valid), o_uart_data_out_ready  RX handshake from UART
// Registers: 0x0 status, 0x4 RX data (pop), 0x8 TX data (push), 0xC levels.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] BASE  = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_we,
    input  logic        i_re,
    output logic [31:0] o_rdata,
    output logic [7:0]  o_uart_data_in,
    output logic        o_uart_data_in_valid,
    input  logic        i_uart_data_in_ready,
    input  logic [7:0]  i_uart_data_out,
    input  logic        i_uart_data_out_valid,
    output logic        o_uart_data_out_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_rdata;
    logic          r_ovf;

    logic          w_in_region;
    logic [27:0]   w_off;
    logic          w_wr;
    logic          w_rd;
    logic          w_rd_status;
    logic          w_tx_push;
    logic          w_tx_pop;
    logic          w_rx_pop;
    logic          w_ovf_set;
    logic [31:0]   w_rdata_d;

    logic          w_tx_full;
    logic          w_tx_empty;
    logic [CW-1:0] w_tx_count;
    logic          w_rx_full;
    logic          w_rx_empty;
    logic [CW-1:0] w_rx_count;
    logic [7:0]    w_rx_head;
    logic          w_unused_wdata;

    assign w_unused_wdata = ^i_wdata[31:8];

    assign w_in_region = (i_addr[31:28] == BASE[31:28]);
    assign w_off       = i_addr[27:0] - BASE[27:0];
    assign w_wr        = i_we && w_in_region;
    // A simultaneous store wins: the load side has no effect and returns 0.
    assign w_rd        = i_re && !i_we && w_in_region;
    assign w_rd_status = w_rd && (w_off == OFF_STATUS);

    // TX fullness is judged before the edge, so a drain in the same cycle
    // does not rescue a store into a full FIFO.
    assign w_tx_push = w_wr && (w_off == OFF_TXDATA) && !w_tx_full;
    assign w_tx_pop  = !w_tx_empty && i_uart_data_in_ready;

    assign w_rx_pop  = w_rd && (w_off == OFF_RXDATA) && !w_rx_empty;
    assign w_ovf_set = i_uart_data_out_valid && w_rx_full && !w_rx_pop;

    assign o_uart_data_in_valid  = !w_tx_empty;
    assign o_uart_data_out_ready = 1'b1;
    assign o_rdata               = r_rdata;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_tx_push),
        .i_wdata (i_wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_rdata (o_uart_data_in),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    // Push-while-full with a CPU pop is accepted inside the FIFO.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_uart_data_out_valid),
        .i_wdata (i_uart_data_out),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count)
    );

    always_comb begin
        w_rdata_d = '0;
        if (w_rd) begin
            case (w_off)
                OFF_STATUS: begin
                    w_rdata_d[ST_TX_NOT_FULL]  = !w_tx_full;
                    w_rdata_d[ST_RX_NOT_EMPTY] = !w_rx_empty;
                    // Report an overflow that is being set this very cycle.
                    w_rdata_d[ST_RX_OVF]       = r_ovf || w_ovf_set;
                end
                OFF_RXDATA: w_rdata_d = {24'b0, w_rx_head};
                OFF_LEVELS: w_rdata_d = {16'b0, 8'(w_rx_count), 8'(w_tx_count)};
                default:    w_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (i_re) r_rdata <= w_rdata_d;
            if (w_ovf_set)        r_ovf <= 1'b1;
            else if (w_rd_status) r_ovf <= 1'b0;
        end
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sequences the UART on behalf of the MIPS150 core. Buffers outgoing bytes from CPU stores in a TX FIFO and drains them into the UART transmitter. Buffers incoming bytes from the UART receiver in an RX FIFO for CPU loads. Sits between the CPU data-memory port (the 0x8000_00xx I/O region) and the UART's DataIn/DataOut handshakes.

## Interface
- DEPTH, 8: entries per FIFO; power of two, minimum 2.
- BASE, 32'h8000_0000: I/O region base; decode uses Addr[31:28] == BASE[31:28].

- Clock  in  1  single clock for all state.
- Reset_n  in  1  asynchronous, active-low reset.
- Addr  in  32  CPU byte address; word-aligned.
- WData  in  32  CPU store data.
- WE  in  1  store strobe, one cycle per access.
- RE  in  1  load strobe, one cycle per access.
- RData  out  32  load result, registered.
- UartDataIn  out  8  byte to the UART transmitter.
- UartDataInValid  out  1  TX byte valid.
- UartDataInReady  in  1  transmitter accepts the byte.
- UartDataOut  in  8  byte from the UART receiver.
- UartDataOutValid  in  1  RX byte valid.
- UartDataOutReady  out  1  constant 1; the receiver is always drained.

## Operation
Register map (offset from BASE):
- 0x00 status (R): bit0 = TX not full; bit1 = RX not empty; bit2 = RX overflow (sticky). Reading this register clears bit2. Bits [31:3] read 0.
- 0x04 RX data (R): returns {24'b0, head byte} and pops the head. A read while empty returns 0 and does not pop.
- 0x08 TX data (W): pushes WData[7:0]. A write while full is dropped; FIFO state is unchanged.
- 0x0C levels (R): {16'b0, rx_count[7:0], tx_count[7:0]}. Counts range 0..DEPTH.
- Any other offset, or an address outside the region: reads return 0, writes are ignored. WE and RE high together: the write is performed and RData returns 0.

TX path:
- UartDataInValid = !tx_empty.
- UartDataIn = TX head byte.
- Pop when Valid && Ready on a rising edge.

RX path:
- A byte is pushed on every cycle where UartDataOutValid = 1.
- If the RX FIFO is full and no CPU pop happens in that cycle, the byte is discarded and overflow is set.

Pointer arithmetic:
- Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- The count register is log2(DEPTH)+1 bits and distinguishes full from empty.

## Timing
- Reset (async assert, sync-safe deassert): both FIFOs empty, counts 0, overflow 0, RData 0, UartDataInValid 0, UartDataIn 0. Bytes in flight are lost.
- Load latency is 1 cycle: RData is valid on the cycle after RE and holds until the next RE. The pop takes effect at the same edge that captures RData.
- Store latency: a byte written at edge N is visible as UartDataInValid = 1 after edge N when the FIFO was empty. Status bit0 and the levels register reflect the write from cycle N+1.
- Same-cycle RX push and CPU pop while full: both succeed, count stays DEPTH, no overflow.
- Same-cycle RX push and CPU pop while empty: RData = 0 and the pushed byte is stored.
- Same-cycle TX push and UART pop:
  - While full: the CPU write is dropped, because fullness is evaluated pre-edge.
  - Otherwise: both occur and the count is unchanged.
- Overflow set and status read in the same cycle: RData bit2 = 1, and overflow ends set. A set takes priority over the clear.
- No multi-cycle state machine on the CPU side. Every access completes in one cycle and the CPU never stalls.

## Structure
- Shared package `uart_mmio_pkg`: register offset constants (STATUS=0x0, RXDATA=0x4, TXDATA=0x8, LEVELS=0xC) and status bit indices.
- One sub-module `sync_fifo`, parameterised by WIDTH and DEPTH, with push/pop/full/empty/count. It is instantiated twice (RX, TX).
- Top level holds only address decode, the RData register, the overflow flag and the UART wiring.

## Test plan
- Reset → RData = 0, UartDataInValid = 0, status read = 32'h1. Deassert reset mid-sequence and confirm the FIFOs are empty.
- Store 0x41, 0x42, 0x43 to 0x08 with UartDataInReady = 1 every other cycle → the UART sees 0x41, 0x42, 0x43 in order; levels reads tx_count = 0 afterwards.
- Hold UartDataInReady = 0, store DEPTH+2 bytes → status bit0 = 0 after DEPTH stores; levels = DEPTH; the last 2 bytes never appear.
- Inject 0x7A on the RX port → status = 32'h3; read 0x04 → RData = 32'h7A on the next cycle; status returns to 32'h1.
- Inject DEPTH+1 RX bytes without reads → status bit2 = 1. The read clears it; the next status read has bit2 = 0. The FIFO holds the first DEPTH bytes.
- Full RX FIFO, RX push and 0x04 read in the same cycle → no overflow, rx_count stays DEPTH, RData = oldest byte.
